cordic_share_arbiter: RTL and testbench



---
 rtl/cordic_share_arbiter.sv | 276 +++++++++++++++++++++++++++
 tb/tb_cordic_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_share_arbiter.sv
// Round-robin owner arbiter that shares one doubly-pipelined CORDIC among NREQ requesters.
// Define CORDIC_ARB_FIXED_PRIO_EN to select fixed lowest-index-first priority instead of round-robin.
module cordic_share_arbiter #(
    parameter int NREQ          = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int CNT_W         = 6
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NREQ-1:0]                 req,
    output logic [NREQ-1:0]                 gnt,
    input  logic [NREQ-1:0]                 req_nrst,
    input  logic [NREQ-1:0]                 req_vec_en,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_vec_xin,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_vec_yin,
    input  logic [NREQ-1:0]                 req_vec_ang_en,
    input  logic [NREQ-1:0]                 req_rot_en,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_rot_xin,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_rot_yin,
    input  logic [NREQ*ANGLE_WIDTH-1:0]     req_rot_ang_in,
    input  logic [NREQ-1:0]                 req_rot_mr_n,
    input  logic [NREQ*CORDIC_STAGES-1:0]   req_rot_mr_ext,
    input  logic [NREQ-1:0]                 req_rot_mr_vld,
    input  logic [NREQ*2-1:0]               req_rot_quad,
    output logic                            cordic_nrst,
    output logic                            cordic_vec_en,
    output logic [DATA_WIDTH-1:0]           cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]           cordic_vec_yin,
    output logic                            cordic_vec_ang_en,
    output logic                            cordic_rot_en,
    output logic [DATA_WIDTH-1:0]           cordic_rot_xin,
    output logic [DATA_WIDTH-1:0]           cordic_rot_yin,
    output logic [ANGLE_WIDTH-1:0]          cordic_rot_ang_in,
    output logic                            cordic_rot_mr_n,
    output logic [CORDIC_STAGES-1:0]        cordic_rot_mr_ext,
    output logic                            cordic_rot_mr_vld,
    output logic [1:0]                      cordic_rot_quad,
    input  logic                            cordic_vec_opvld,
    input  logic                            cordic_rot_opvld,
    output logic [NREQ-1:0]                 vec_opvld,
    output logic [NREQ-1:0]                 rot_opvld,
    output logic                            ovf_err
);

    localparam int IDX_W = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [NREQ-1:0]        gnt_r, gnt_s;
    logic [IDX_W-1:0]       owner_r, owner_s;
    logic [CNT_W-1:0]       vec_cnt_r, rot_cnt_r;
    logic                   ovf_err_r;
    logic [IDX_W:0]         pick_s;
    logic [CNT_W:0]         vec_step_s, rot_step_s;
    logic                   soft_clr_s;
    logic                   stray_s;

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    // Lowest asserted index wins; returns {found, index}.
    function automatic logic [IDX_W:0] arb_pick(input logic [NREQ-1:0] r);
        logic             found;
        logic [IDX_W-1:0] win;
        found = 1'b0;
        win   = {IDX_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!found && r[k]) begin
                found = 1'b1;
                win   = IDX_W'(k);
            end
        end
        return {found, win};
    endfunction
`else
    logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_s;

    // First asserted index at or above ptr, wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] arb_pick(input logic [NREQ-1:0] r,
                                                input logic [IDX_W-1:0] ptr);
        logic [2*NREQ-1:0] rot;
        logic              found;
        logic [IDX_W-1:0]  win;
        int                sum;
        rot   = {r, r} >> ptr;
        found = 1'b0;
        win   = {IDX_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                win = IDX_W'(sum);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] win);
        int nx;
        nx = int'(win) + 1;
        if (nx >= NREQ) begin
            nx = 0;
        end
        return IDX_W'(nx);
    endfunction
`endif

    // Saturating up/down counter step; returns {error, next_count}.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
        logic [CNT_W:0] res;
        case ({inc, dec})
            2'b10: begin
                if (c == {CNT_W{1'b1}}) res = {1'b1, c};
                else                    res = {1'b0, c + CNT_W'(1)};
            end
            2'b01: begin
                if (c == {CNT_W{1'b0}}) res = {1'b1, c};
                else                    res = {1'b0, c - CNT_W'(1)};
            end
            default: res = {1'b0, c};
        endcase
        return res;
    endfunction

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    assign pick_s = arb_pick(req);
`else
    assign pick_s = arb_pick(req, rr_ptr_r);
`endif

    // Next-state, next-owner and pointer logic.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        owner_s = owner_r;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
        rr_ptr_s = rr_ptr_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_s[IDX_W]) begin
                    state_s = GRANT;
                    owner_s = pick_s[IDX_W-1:0];
                    gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s[IDX_W-1:0];
`ifndef CORDIC_ARB_FIXED_PRIO_EN
                    rr_ptr_s = ptr_after(pick_s[IDX_W-1:0]);
`endif
                end else begin
                    gnt_s = {NREQ{1'b0}};
                end
            end
            GRANT: begin
                if (!req[owner_r]) begin
                    state_s = DRAIN;
                end else begin
                    state_s = GRANT;
                end
            end
            DRAIN: begin
                if ((vec_cnt_r == {CNT_W{1'b0}}) && (rot_cnt_r == {CNT_W{1'b0}})) begin
                    if (pick_s[IDX_W]) begin
                        state_s = GRANT;
                        owner_s = pick_s[IDX_W-1:0];
                        gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s[IDX_W-1:0];
`ifndef CORDIC_ARB_FIXED_PRIO_EN
                        rr_ptr_s = ptr_after(pick_s[IDX_W-1:0]);
`endif
                    end else begin
                        state_s = IDLE;
                        gnt_s   = {NREQ{1'b0}};
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {NREQ{1'b0}};
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            gnt_r    <= {NREQ{1'b0}};
            owner_r  <= {IDX_W{1'b0}};
`ifndef CORDIC_ARB_FIXED_PRIO_EN
            rr_ptr_r <= {IDX_W{1'b0}};
`endif
        end else begin
            state_r  <= state_s;
            gnt_r    <= gnt_s;
            owner_r  <= owner_s;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
            rr_ptr_r <= rr_ptr_s;
`endif
        end
    end

    // Owner mux: data follows any held owner, strobes only while it holds GRANT.
    always_comb begin
        cordic_vec_en     = 1'b0;
        cordic_vec_ang_en = 1'b0;
        cordic_rot_en     = 1'b0;
        cordic_rot_mr_vld = 1'b0;
        cordic_rot_mr_n   = 1'b0;
        cordic_vec_xin    = {DATA_WIDTH{1'b0}};
        cordic_vec_yin    = {DATA_WIDTH{1'b0}};
        cordic_rot_xin    = {DATA_WIDTH{1'b0}};
        cordic_rot_yin    = {DATA_WIDTH{1'b0}};
        cordic_rot_ang_in = {ANGLE_WIDTH{1'b0}};
        cordic_rot_mr_ext = {CORDIC_STAGES{1'b0}};
        cordic_rot_quad   = 2'b00;
        if (gnt_r != {NREQ{1'b0}}) begin
            cordic_vec_xin    = req_vec_xin[owner_r*DATA_WIDTH +: DATA_WIDTH];
            cordic_vec_yin    = req_vec_yin[owner_r*DATA_WIDTH +: DATA_WIDTH];
            cordic_rot_xin    = req_rot_xin[owner_r*DATA_WIDTH +: DATA_WIDTH];
            cordic_rot_yin    = req_rot_yin[owner_r*DATA_WIDTH +: DATA_WIDTH];
            cordic_rot_ang_in = req_rot_ang_in[owner_r*ANGLE_WIDTH +: ANGLE_WIDTH];
            cordic_rot_mr_ext = req_rot_mr_ext[owner_r*CORDIC_STAGES +: CORDIC_STAGES];
            cordic_rot_quad   = req_rot_quad[owner_r*2 +: 2];
            cordic_rot_mr_n   = req_rot_mr_n[owner_r];
        end else begin
            cordic_rot_quad   = 2'b00;
        end
        if (state_r == GRANT) begin
            cordic_vec_en     = req_vec_en[owner_r];
            cordic_vec_ang_en = req_vec_ang_en[owner_r];
            cordic_rot_en     = req_rot_en[owner_r];
            cordic_rot_mr_vld = req_rot_mr_vld[owner_r];
        end else begin
            cordic_vec_en     = 1'b0;
        end
    end

    assign soft_clr_s  = (state_r == GRANT) && !req_nrst[owner_r];
    assign cordic_nrst = rstn & ((state_r == GRANT) ? req_nrst[owner_r] : 1'b1);
    assign stray_s     = (cordic_vec_opvld | cordic_rot_opvld) && (gnt_r == {NREQ{1'b0}});
    assign vec_step_s  = cnt_step(vec_cnt_r, cordic_vec_en, cordic_vec_opvld);
    assign rot_step_s  = cnt_step(rot_cnt_r, cordic_rot_en, cordic_rot_opvld);

    // In-flight counters and sticky over/underflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_cnt_r <= {CNT_W{1'b0}};
            rot_cnt_r <= {CNT_W{1'b0}};
            ovf_err_r <= 1'b0;
        end else begin
            if (soft_clr_s) begin
                vec_cnt_r <= {CNT_W{1'b0}};
                rot_cnt_r <= {CNT_W{1'b0}};
            end else begin
                vec_cnt_r <= vec_step_s[CNT_W-1:0];
                rot_cnt_r <= rot_step_s[CNT_W-1:0];
            end
            ovf_err_r <= ovf_err_r | vec_step_s[CNT_W] | rot_step_s[CNT_W] | stray_s;
        end
    end

    assign gnt       = gnt_r;
    assign ovf_err   = ovf_err_r;
    assign vec_opvld = {NREQ{cordic_vec_opvld}} & gnt_r;
    assign rot_opvld = {NREQ{cordic_rot_opvld}} & gnt_r;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Directed self-checking bench for cordic_share_arbiter (NREQ=3, default widths).
// The CORDIC result strobes are driven by the bench to model in-flight operations.
module tb_cordic_share_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int CS   = 16;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic                 clk;
    logic                 rstn;
    logic [NREQ-1:0]      req, gnt, req_nrst, req_vec_en, req_vec_ang_en;
    logic [NREQ-1:0]      req_rot_en, req_rot_mr_n, req_rot_mr_vld;
    logic [NREQ*DW-1:0]   req_vec_xin, req_vec_yin, req_rot_xin, req_rot_yin;
    logic [NREQ*AW-1:0]   req_rot_ang_in;
    logic [NREQ*CS-1:0]   req_rot_mr_ext;
    logic [NREQ*2-1:0]    req_rot_quad;
    logic                 cordic_nrst, cordic_vec_en, cordic_vec_ang_en;
    logic [DW-1:0]        cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin;
    logic                 cordic_rot_en, cordic_rot_mr_n, cordic_rot_mr_vld;
    logic [AW-1:0]        cordic_rot_ang_in;
    logic [CS-1:0]        cordic_rot_mr_ext;
    logic [1:0]           cordic_rot_quad;
    logic                 cordic_vec_opvld, cordic_rot_opvld;
    logic [NREQ-1:0]      vec_opvld, rot_opvld;
    logic                 ovf_err;

    int n_checks = 0;
    int n_fails  = 0;

    cordic_share_arbiter dut (
        .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .req_nrst(req_nrst),
        .req_vec_en(req_vec_en), .req_vec_xin(req_vec_xin), .req_vec_yin(req_vec_yin),
        .req_vec_ang_en(req_vec_ang_en), .req_rot_en(req_rot_en),
        .req_rot_xin(req_rot_xin), .req_rot_yin(req_rot_yin),
        .req_rot_ang_in(req_rot_ang_in), .req_rot_mr_n(req_rot_mr_n),
        .req_rot_mr_ext(req_rot_mr_ext), .req_rot_mr_vld(req_rot_mr_vld),
        .req_rot_quad(req_rot_quad), .cordic_nrst(cordic_nrst),
        .cordic_vec_en(cordic_vec_en), .cordic_vec_xin(cordic_vec_xin),
        .cordic_vec_yin(cordic_vec_yin), .cordic_vec_ang_en(cordic_vec_ang_en),
        .cordic_rot_en(cordic_rot_en), .cordic_rot_xin(cordic_rot_xin),
        .cordic_rot_yin(cordic_rot_yin), .cordic_rot_ang_in(cordic_rot_ang_in),
        .cordic_rot_mr_n(cordic_rot_mr_n), .cordic_rot_mr_ext(cordic_rot_mr_ext),
        .cordic_rot_mr_vld(cordic_rot_mr_vld), .cordic_rot_quad(cordic_rot_quad),
        .cordic_vec_opvld(cordic_vec_opvld), .cordic_rot_opvld(cordic_rot_opvld),
        .vec_opvld(vec_opvld), .rot_opvld(rot_opvld), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] order [3];
        rstn = 1'b0; req = '0; req_nrst = '1; req_vec_en = '0; req_vec_ang_en = '0;
        req_rot_en = '0; req_rot_mr_n = '0; req_rot_mr_vld = '0;
        req_vec_xin = {16'hcccc, 16'hbbbb, 16'haaaa}; req_vec_yin = '0;
        req_rot_xin = {16'h3333, 16'h2222, 16'h1111}; req_rot_yin = '0;
        req_rot_ang_in = '0; req_rot_mr_ext = '0; req_rot_quad = '0;
        cordic_vec_opvld = 1'b0; cordic_rot_opvld = 1'b0;
        cyc(); cyc();
        check_val("rst_gnt", 64'(gnt), 64'h0);
        check_val("rst_nrst", 64'(cordic_nrst), 64'h0);
        check_val("rst_ven", 64'(cordic_vec_en), 64'h0);
        check_val("rst_ovf", 64'(ovf_err), 64'h0);
        rstn = 1'b1;

        // single owner, three vectoring ops, drain
        req = 3'b001;
        cyc();
        check_val("t1_gnt", 64'(gnt), 64'h1);
        check_val("t1_state", 64'(dut.state_r), 64'(S_GRANT));
        req_vec_en = 3'b001;
        #1;
        check_val("t1_ven", 64'(cordic_vec_en), 64'h1);
        check_val("t1_vxin", 64'(cordic_vec_xin), 64'haaaa);
        cyc(); cyc(); cyc();
        req_vec_en = 3'b000; req = 3'b000;
        cyc();
        check_val("t1_drain", 64'(dut.state_r), 64'(S_DRAIN));
        check_val("t1_gnt_hold", 64'(gnt), 64'h1);
        check_val("t1_cnt3", 64'(dut.vec_cnt_r), 64'h3);
        req_vec_en = 3'b001;
        #1;
        check_val("t1_ven_drain", 64'(cordic_vec_en), 64'h0);
        req_vec_en = 3'b000;
        cordic_vec_opvld = 1'b1;
        #1;
        check_val("t1_vopvld", 64'(vec_opvld), 64'h1);
        cyc(); cyc(); cyc();
        cordic_vec_opvld = 1'b0;
        check_val("t1_cnt0", 64'(dut.vec_cnt_r), 64'h0);
        check_val("t1_still_drain", 64'(dut.state_r), 64'(S_DRAIN));
        cyc();
        check_val("t1_gnt_clr", 64'(gnt), 64'h0);
        check_val("t1_idle", 64'(dut.state_r), 64'(S_IDLE));
        check_val("t1_ovf", 64'(ovf_err), 64'h0);

        // all requesting, each owner does one rotation then re-requests
        do_reset();
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        order[0] = 2'd0; order[1] = 2'd0; order[2] = 2'd0;
`else
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
`endif
        req = 3'b111;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check_val("t2_gnt", 64'(gnt), 64'(3'b001 << order[i]));
            req_rot_en = 3'b001 << order[i];
            #1;
            check_val("t2_ren", 64'(cordic_rot_en), 64'h1);
            check_val("t2_rxin", 64'(cordic_rot_xin), 64'(16'h1111 * (16'(order[i]) + 16'd1)));
            cyc();
            req_rot_en = 3'b000;
            req[order[i]] = 1'b0;
            cyc();
            cordic_rot_opvld = 1'b1;
            #1;
            check_val("t2_ropvld", 64'(rot_opvld), 64'(3'b001 << order[i]));
            cyc();
            cordic_rot_opvld = 1'b0;
            req[order[i]] = 1'b1;
            cyc();
        end
        check_val("t2_gnt_wrap", 64'(gnt), 64'h1);

        // non-owner strobe is ignored
        req_vec_en = 3'b100;
        #1;
        check_val("t3_ven", 64'(cordic_vec_en), 64'h0);
        cyc();
        req_vec_en = 3'b000;
        check_val("t3_cnt", 64'(dut.vec_cnt_r), 64'h0);

        // owner soft reset with two ops in flight
        req = 3'b110;
        cyc(); cyc();
        check_val("t4_gnt", 64'(gnt), 64'h2);
        req_vec_en = 3'b010;
        cyc(); cyc();
        req_vec_en = 3'b000;
        check_val("t4_cnt2", 64'(dut.vec_cnt_r), 64'h2);
        req_nrst = 3'b101;
        #1;
        check_val("t4_nrst_low", 64'(cordic_nrst), 64'h0);
        cyc();
        req_nrst = 3'b111;
        #1;
        check_val("t4_nrst_high", 64'(cordic_nrst), 64'h1);
        check_val("t4_cnt_clr", 64'(dut.vec_cnt_r), 64'h0);
        check_val("t4_gnt_keep", 64'(gnt), 64'h2);

        // async reset mid-grant
        req_rot_en = 3'b010;
        cyc(); cyc(); cyc(); cyc();
        req_rot_en = 3'b000;
        check_val("t5_rcnt4", 64'(dut.rot_cnt_r), 64'h4);
        rstn = 1'b0;
        #1;
        check_val("t5_gnt", 64'(gnt), 64'h0);
        check_val("t5_nrst", 64'(cordic_nrst), 64'h0);
        check_val("t5_rcnt", 64'(dut.rot_cnt_r), 64'h0);
        check_val("t5_state", 64'(dut.state_r), 64'(S_IDLE));
        req = 3'b000;
        cyc();
        rstn = 1'b1;

        // arbitration policy after a handover
        req = 3'b110;
        cyc();
        check_val("t6_gnt110", 64'(gnt), 64'h2);
        req = 3'b100;
        cyc();
        req = 3'b110;
        cyc();
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        check_val("t6_handover", 64'(gnt), 64'h2);
`else
        check_val("t6_handover", 64'(gnt), 64'h4);
`endif
        req = 3'b000;
        do_reset();

        // stray result strobe with no owner
        cordic_vec_opvld = 1'b1;
        #1;
        check_val("t6_vopvld", 64'(vec_opvld), 64'h0);
        cyc();
        cordic_vec_opvld = 1'b0;
        check_val("t6_ovf_set", 64'(ovf_err), 64'h1);
        check_val("t6_cnt_sat", 64'(dut.vec_cnt_r), 64'h0);
        cyc(); cyc();
        check_val("t6_ovf_hold", 64'(ovf_err), 64'h1);
        do_reset();
        check_val("t6_ovf_clr", 64'(ovf_err), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
